// File: rtl/latch_pkg.sv
// ---------------------------------------------------------------------------
// latch_pkg
// Shared types and defaults for the latch-to-serial bridge.
//   capture_state_t : capture FSM (idle / enable latch output / sample bus)
//   ser_state_t     : serializer FSM (idle / load shift register / shift)
//   DEF_DEPTH       : default FIFO depth
//   DEF_BIT_CYC     : default clk cycles per serial bit
// ---------------------------------------------------------------------------
package latch_pkg;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_BIT_CYC = 4;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_EN   = 2'd1,
      C_SAMP = 2'd2
   } capture_state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } ser_state_t;

   // The upstream latch drives the bus while we enable it and while we sample.
   function automatic logic oe_active(input capture_state_t s);
      return (s == C_EN) || (s == C_SAMP);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Byte-wide FIFO, DEPTH entries (power of two), no write-to-read bypass.
//   clk, rst_b : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write din at the tail
//   pop, dout  : dout shows the head; pop advances past it
//   full/empty : occupancy flags, cnt : current occupancy
// ---------------------------------------------------------------------------
module byte_fifo
   import latch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    push,
   input  logic                    pop,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; stale contents are unreachable once cnt is 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   // Head is read straight from storage, never from din.
   assign dout  = mem[rd_ptr_q];
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign cnt   = cnt_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_b) !(push && full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_b) !(pop && empty));

endmodule

// File: rtl/latch_serializer.sv
// ---------------------------------------------------------------------------
// latch_serializer
// Pulls bytes from an upstream octal latch (enabling its outputs for one
// settle cycle before sampling), queues them, and shifts them out MSB first.
//   clk, rst_b         : clock, asynchronous active-low reset
//   bus_d, bus_oe_b    : latch Q outputs / latch output enable (low = drive)
//   req, ack           : byte waiting (level) / byte taken (1-cycle pulse)
//   ser_out, ser_clk   : serial data, bit clock (high in 2nd half of a bit)
//   frame              : high for the 8 bit periods of each byte
//   fifo_full/empty/cnt: queue status
// ---------------------------------------------------------------------------
module latch_serializer
   import latch_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int BIT_CYC = DEF_BIT_CYC
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic [7:0]              bus_d,
   output logic                    bus_oe_b,
   input  logic                    req,
   output logic                    ack,
   output logic                    ser_out,
   output logic                    ser_clk,
   output logic                    frame,
   output logic                    fifo_full,
   output logic                    fifo_empty,
   output logic [$clog2(DEPTH):0]  fifo_cnt
);

   localparam int PW = $clog2(BIT_CYC);
   localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYC / 2);
   localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYC - 1);

   logic       push, pop;
   logic [7:0] fifo_dout;

   // ---------------- capture FSM ----------------
   capture_state_t cap_q, cap_d;
   logic           bus_oe_b_q, bus_oe_b_d;
   logic           ack_q, ack_d;

   // Outputs are registered from the next state so bus_oe_b never glitches.
   always_comb begin
      cap_d = cap_q;
      case (cap_q)
         C_IDLE:  if (req && !fifo_full) cap_d = C_EN;
         C_EN:    cap_d = C_SAMP;
         C_SAMP:  cap_d = C_IDLE;
         default: cap_d = C_IDLE;
      endcase
      bus_oe_b_d = !oe_active(cap_d);
      ack_d      = (cap_d == C_SAMP);
   end

   assign push = (cap_q == C_SAMP);

   // ---------------- serializer FSM + shift datapath ----------------
   ser_state_t    ser_q, ser_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          ser_out_q, ser_out_d;
   logic          ser_clk_q, ser_clk_d;
   logic          frame_q, frame_d;

   always_comb begin
      ser_d     = ser_q;
      shreg_d   = shreg_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
      case (ser_q)
         S_IDLE: if (!fifo_empty) ser_d = S_LOAD;
         S_LOAD: begin
            pop       = 1'b1;
            shreg_d   = fifo_dout;
            phase_d   = '0;
            bit_cnt_d = '0;
            ser_d     = S_SHIFT;
         end
         S_SHIFT: begin
            if (phase_q == PH_LAST) begin
               shreg_d   = {shreg_q[6:0], 1'b0};
               phase_d   = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) ser_d = fifo_empty ? S_IDLE : S_LOAD;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: ser_d = S_IDLE;
      endcase
      // Serial outputs are decoded from next state and registered.
      frame_d   = (ser_d == S_SHIFT);
      ser_out_d = frame_d & shreg_d[7];
      ser_clk_d = frame_d & (phase_d >= PH_HALF);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cap_q      <= C_IDLE;
         bus_oe_b_q <= 1'b1;
         ack_q      <= 1'b0;
         ser_q      <= S_IDLE;
         shreg_q    <= '0;
         phase_q    <= '0;
         bit_cnt_q  <= '0;
         ser_out_q  <= 1'b0;
         ser_clk_q  <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         cap_q      <= cap_d;
         bus_oe_b_q <= bus_oe_b_d;
         ack_q      <= ack_d;
         ser_q      <= ser_d;
         shreg_q    <= shreg_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         ser_out_q  <= ser_out_d;
         ser_clk_q  <= ser_clk_d;
         frame_q    <= frame_d;
      end
   end

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .pop   (pop),
      .din   (bus_d),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

   assign bus_oe_b = bus_oe_b_q;
   assign ack      = ack_q;
   assign ser_out  = ser_out_q;
   assign ser_clk  = ser_clk_q;
   assign frame    = frame_q;

endmodule
